mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_rsp_slot.sv | 42 ++++
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter: funct3 size codes
// and the owner of the shared memory port in a given cycle.
package mem_arb_pkg;

  localparam logic [2:0] MEM_BYTE = 3'b000;
  localparam logic [2:0] MEM_HALF = 3'b001;
  localparam logic [2:0] MEM_WORD = 3'b010;
  localparam logic [2:0] MEM_LBU  = 3'b100;
  localparam logic [2:0] MEM_LHU  = 3'b101;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_D
  } owner_t;

endpackage

// File: rtl/mem_rsp_slot.sv
// One-entry response buffer with a valid/ready output handshake; o_free says
// the entry can accept a new response this cycle (empty or being drained).
module mem_rsp_slot #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DWIDTH-1:0] i_data,
  input  logic              i_err,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DWIDTH-1:0] o_data,
  output logic              o_err,
  output logic              o_free
);

  logic              r_valid;
  logic [DWIDTH-1:0] r_data;
  logic              r_err;

  // A load always wins over a drain so a drain and refill in one cycle keeps valid high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_err   <= i_err;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_err   = r_err;
  assign o_free  = !r_valid || i_ready;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch and a data requester onto one memory port.
// Define MEM_ARB_RR_EN for round-robin on contention; otherwise data has priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int                 AWIDTH    = 32,
  parameter int                 DWIDTH    = 32,
  parameter logic [AWIDTH-1:0]  BASE_ADDR = AWIDTH'(32'h01000000),
  parameter int unsigned        MEM_BYTES = 1048576
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [AWIDTH-1:0] if_addr,
  output logic              if_rsp_valid,
  input  logic              if_rsp_ready,
  output logic [DWIDTH-1:0] if_rsp_data,
  output logic              if_rsp_err,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_we,
  input  logic [AWIDTH-1:0] d_addr,
  input  logic [DWIDTH-1:0] d_wdata,
  input  logic [2:0]        d_size,
  output logic              d_rsp_valid,
  input  logic              d_rsp_ready,
  output logic [DWIDTH-1:0] d_rsp_data,
  output logic              d_rsp_err,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic [2:0]        mem_size_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  input  logic [DWIDTH-1:0] mem_data_i
);

  // One extra bit so the window check cannot wrap past the top of the address space.
  localparam logic [AWIDTH:0] BASE_X  = {1'b0, BASE_ADDR};
  localparam logic [AWIDTH:0] LIMIT_X = BASE_X + (AWIDTH+1)'(MEM_BYTES);

  function automatic logic outOfRange(input logic [AWIDTH-1:0] addr);
    logic [AWIDTH:0] addrX;
    addrX = {1'b0, addr};
    return (addrX < BASE_X) || ((addrX + (AWIDTH+1)'(3)) >= LIMIT_X);
  endfunction

  owner_t            w_owner;
  logic              w_ifFree, w_dFree;
  logic              w_ifElig, w_dElig, w_contend;
  logic              w_ifErr, w_dErr;
  logic [DWIDTH-1:0] w_ifRspData, w_dRspData;

  assign w_ifElig  = if_req_valid && w_ifFree;
  assign w_dElig   = d_req_valid && w_dFree;
  assign w_contend = w_ifElig && w_dElig;
  assign w_ifErr   = (if_addr[1:0] != 2'b00) || outOfRange(if_addr);
  assign w_dErr    = outOfRange(d_addr);

`ifdef MEM_ARB_RR_EN
  owner_t r_rrLast;

  // Remembers the winner of the last contended cycle; resets as if fetch won last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rrLast <= OWN_IF;
    end else if (w_contend) begin
      r_rrLast <= w_owner;
    end
  end
`endif

  always_comb begin
    w_owner = OWN_NONE;
    if (!rst) begin
      w_owner = OWN_NONE;
    end else if (w_contend) begin
`ifdef MEM_ARB_RR_EN
      w_owner = (r_rrLast == OWN_D) ? OWN_IF : OWN_D;
`else
      w_owner = OWN_D;
`endif
    end else if (w_dElig) begin
      w_owner = OWN_D;
    end else if (w_ifElig) begin
      w_owner = OWN_IF;
    end
  end

  assign if_req_ready = (w_owner == OWN_IF);
  assign d_req_ready  = (w_owner == OWN_D);

  // Errored grants are still accepted but never reach the memory port.
  always_comb begin
    mem_addr_o     = '0;
    mem_data_o     = '0;
    mem_size_o     = 3'b000;
    mem_read_en_o  = 1'b0;
    mem_write_en_o = 1'b0;
    case (w_owner)
      OWN_IF: begin
        if (!w_ifErr) begin
          mem_addr_o    = if_addr;
          mem_size_o    = MEM_WORD;
          mem_read_en_o = 1'b1;
        end
      end
      OWN_D: begin
        if (!w_dErr) begin
          mem_addr_o = d_addr;
          mem_size_o = d_size;
          if (d_req_we) begin
            mem_write_en_o = 1'b1;
            mem_data_o     = d_wdata;
          end else begin
            mem_read_en_o = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign w_ifRspData = w_ifErr ? '0 : mem_data_i;
  assign w_dRspData  = (w_dErr || d_req_we) ? '0 : mem_data_i;

  mem_rsp_slot #(.DWIDTH(DWIDTH)) u_ifSlot (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_owner == OWN_IF),
    .i_data  (w_ifRspData),
    .i_err   (w_ifErr),
    .i_ready (if_rsp_ready),
    .o_valid (if_rsp_valid),
    .o_data  (if_rsp_data),
    .o_err   (if_rsp_err),
    .o_free  (w_ifFree)
  );

  mem_rsp_slot #(.DWIDTH(DWIDTH)) u_dSlot (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_owner == OWN_D),
    .i_data  (w_dRspData),
    .i_err   (w_dErr),
    .i_ready (d_rsp_ready),
    .o_valid (d_rsp_valid),
    .o_data  (d_rsp_data),
    .o_err   (d_rsp_err),
    .o_free  (w_dFree)
  );

endmodule
